// File: rtl/line_clear_seq.sv
// Tetris line-clear engine: scans one row per cycle, compacts non-full rows downward.
// Optional running score is built when CLEAR_SCORE_EN is defined; otherwise score is tied to 0.
module line_clear_seq #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int CW   = $clog2(ROWS + 1)
) (
    input  logic                 main_clk,
    input  logic                 rst_1plus,
    input  logic                 start,
    input  logic [COLS*ROWS-1:0] board_in,
    output logic                 busy,
    output logic                 done,
    output logic [COLS*ROWS-1:0] board_out,
    output logic [CW-1:0]        lines_cleared,
    output logic [15:0]          score
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_e;

    state_e                     state_q;
    logic [ROWS-1:0][COLS-1:0]  work_q;
    logic [ROWS-1:0][COLS-1:0]  fill_d;
    logic [RW-1:0]              rd_q;
    logic [RW-1:0]              wr_q;
    logic [CW-1:0]              count_q;
    logic [COLS-1:0]            row_d;
    logic                       busy_q;
    logic                       done_q;
    logic [COLS*ROWS-1:0]       board_out_q;
    logic [CW-1:0]              lines_q;

    assign row_d = work_q[rd_q];

    // The top count_q rows are exactly the rows wr never reached, so keying the
    // clear on count avoids needing wr to represent the value ROWS.
    always_comb begin
        fill_d = work_q;
        for (int r = 0; r < ROWS; r++) begin
            if (r + int'(count_q) >= ROWS) fill_d[r] = '0;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the in-place row copy relies on that.
    always_ff @(posedge main_clk or posedge rst_1plus) begin
        if (rst_1plus) begin
            state_q     <= IDLE;
            work_q      <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            board_out_q <= '0;
            lines_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        work_q  <= board_in;
                        rd_q    <= '0;
                        wr_q    <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (&row_d) begin
                        count_q <= count_q + 1'b1;
                    end else begin
                        work_q[wr_q] <= row_d;
                        if (rd_q != RW'(ROWS - 1)) wr_q <= wr_q + 1'b1;
                    end
                    if (rd_q == RW'(ROWS - 1)) state_q <= FILL;
                    else                        rd_q    <= rd_q + 1'b1;
                end
                FILL: begin
                    work_q      <= fill_d;
                    board_out_q <= fill_d;
                    lines_q     <= count_q;
                    done_q      <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign board_out     = board_out_q;
    assign lines_cleared = lines_q;

`ifdef CLEAR_SCORE_EN
    logic [15:0] score_q;
    logic [15:0] pts_d;
    logic [16:0] sum_d;
    int          n_d;

    // Points table collapses to 2n-1 for 1..3 lines and 2n from 4 lines up.
    always_comb begin
        n_d = int'(lines_q);
        if (n_d == 0)      pts_d = '0;
        else if (n_d >= 4) pts_d = 16'(2 * n_d);
        else               pts_d = 16'(2 * n_d - 1);
        sum_d = {1'b0, score_q} + {1'b0, pts_d};
    end

    always_ff @(posedge main_clk or posedge rst_1plus) begin
        if (rst_1plus) begin
            score_q <= '0;
        end else if (state_q == DONE) begin
            score_q <= sum_d[16] ? 16'hFFFF : sum_d[15:0];
        end
    end

    assign score = score_q;
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_line_clear_seq.sv
// Directed bench for line_clear_seq: a 10x20 instance and a 4x4 instance share clock and reset.
module tb_line_clear_seq;

    localparam int WA = 200;
    localparam int WB = 16;
`ifdef CLEAR_SCORE_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_a = 1'b0, start_b = 1'b0;
    logic [WA-1:0] board_a = '0, out_a;
    logic [WB-1:0] board_b = '0, out_b;
    logic          busy_a, done_a, busy_b, done_b;
    logic [4:0]    lines_a;
    logic [2:0]    lines_b;
    logic [15:0]   score_a, score_b;

    int checks   = 0;
    int failures = 0;

    localparam logic [WA-1:0] B1   = (200'h3FF) | (200'h1 << 10) | (200'h1 << 20);
    localparam logic [WA-1:0] E1   = (200'h1) | (200'h1 << 10);
    localparam logic [WA-1:0] B2   = (200'h3FF << 50) | (200'h2AA << 70);
    localparam logic [WA-1:0] E2   = (200'h2AA << 60);

    always #5 clk = ~clk;

    line_clear_seq #(.COLS(10), .ROWS(20)) dut_a (
        .main_clk(clk), .rst_1plus(rst), .start(start_a), .board_in(board_a),
        .busy(busy_a), .done(done_a), .board_out(out_a), .lines_cleared(lines_a), .score(score_a)
    );

    line_clear_seq #(.COLS(4), .ROWS(4)) dut_b (
        .main_clk(clk), .rst_1plus(rst), .start(start_b), .board_in(board_b),
        .busy(busy_b), .done(done_b), .board_out(out_b), .lines_cleared(lines_b), .score(score_b)
    );

    task automatic run_a(input logic [WA-1:0] b, output int cyc);
        board_a = b;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        board_a = '0;
        checks++;
        if (busy_a !== 1'b1) begin failures++; $display("FAIL a_busy_after_start: got %b want 1", busy_a); end
        cyc = 0;
        while (done_a !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        if (done_a !== 1'b1) begin checks++; failures++; $display("FAIL a_done_timeout: no done in %0d cycles", cyc); end
    endtask

    task automatic run_b(input logic [WB-1:0] b, output int cyc);
        board_b = b;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        board_b = '0;
        cyc = 0;
        while (done_b !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        if (done_b !== 1'b1) begin checks++; failures++; $display("FAIL b_done_timeout: no done in %0d cycles", cyc); end
    endtask

    task automatic finish_a(input string tag);
        @(posedge clk); #1;
        checks++;
        if ({busy_a, done_a} !== 2'b00) begin failures++; $display("FAIL %s_idle: busy,done=%b want 00", tag, {busy_a, done_a}); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({busy_a, done_a, lines_a, score_a} !== '0) begin failures++; $display("FAIL reset_a_ctrl: got %h want 0", {busy_a, done_a, lines_a, score_a}); end
        checks++;
        if (out_a !== '0) begin failures++; $display("FAIL reset_a_board: got %h want 0", out_a); end
        checks++;
        if ({busy_b, done_b, lines_b, score_b, out_b} !== '0) begin failures++; $display("FAIL reset_b: got %h want 0", {busy_b, done_b, lines_b, score_b, out_b}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_line();
        int cyc;
        run_a(B1, cyc);
        checks++;
        if (cyc != 21) begin failures++; $display("FAIL single_latency: got %0d want 21", cyc); end
        checks++;
        if (out_a !== E1) begin failures++; $display("FAIL single_board: got %h want %h", out_a, E1); end
        checks++;
        if (lines_a !== 5'd1) begin failures++; $display("FAIL single_lines: got %0d want 1", lines_a); end
        finish_a("single");
        checks++;
        if (score_a !== (SC ? 16'd1 : 16'd0)) begin failures++; $display("FAIL single_score: got %0d want %0d", score_a, SC ? 1 : 0); end
    endtask

    task automatic test_empty();
        int cyc;
        run_a('0, cyc);
        checks++;
        if (cyc != 21) begin failures++; $display("FAIL empty_latency: got %0d want 21", cyc); end
        checks++;
        if ({out_a, lines_a} !== '0) begin failures++; $display("FAIL empty_result: board %h lines %0d want 0/0", out_a, lines_a); end
        finish_a("empty");
        checks++;
        if (score_a !== (SC ? 16'd1 : 16'd0)) begin failures++; $display("FAIL empty_score: got %0d want %0d", score_a, SC ? 1 : 0); end
    endtask

    task automatic test_small_board();
        int cyc;
        run_b(16'hFFFF, cyc);
        checks++;
        if (cyc != 5) begin failures++; $display("FAIL b_full_latency: got %0d want 5", cyc); end
        checks++;
        if (out_b !== 16'h0000 || lines_b !== 3'd4) begin failures++; $display("FAIL b_full: board %h lines %0d want 0000/4", out_b, lines_b); end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (score_b !== (SC ? 16'd8 : 16'd0)) begin failures++; $display("FAIL b_full_score: got %0d want %0d", score_b, SC ? 8 : 0); end

        run_b(16'h3F5F, cyc);
        checks++;
        if (out_b !== 16'h0035 || lines_b !== 3'd2) begin failures++; $display("FAIL b_mixed: board %h lines %0d want 0035/2", out_b, lines_b); end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (score_b !== (SC ? 16'd11 : 16'd0)) begin failures++; $display("FAIL b_mixed_score: got %0d want %0d", score_b, SC ? 11 : 0); end

        run_b(16'h1234, cyc);
        checks++;
        if (out_b !== 16'h1234 || lines_b !== 3'd0) begin failures++; $display("FAIL b_nofull: board %h lines %0d want 1234/0", out_b, lines_b); end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (busy_b !== 1'b0 || score_b !== (SC ? 16'd11 : 16'd0)) begin failures++; $display("FAIL b_nofull_tail: busy %b score %0d", busy_b, score_b); end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        int first = 0;
        board_a = B2;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        board_a = '1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
            if (done_a === 1'b1) begin
                dones++;
                if (first == 0) first = c;
            end
        end
        board_a = '0;
        checks++;
        if (dones != 1 || first != 21) begin failures++; $display("FAIL ignore_done_count: dones %0d at %0d want 1 at 21", dones, first); end
        checks++;
        if (out_a !== E2 || lines_a !== 5'd1) begin failures++; $display("FAIL ignore_result: board %h lines %0d want %h/1", out_a, lines_a, E2); end
        checks++;
        if (score_a !== (SC ? 16'd2 : 16'd0)) begin failures++; $display("FAIL ignore_score: got %0d want %0d", score_a, SC ? 2 : 0); end
    endtask

    task automatic test_back_to_back();
        int d1 = 0;
        int d2 = 0;
        int dones = 0;
        board_a = B1;
        start_a = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            if (done_a === 1'b1) begin
                dones++;
                if (d1 == 0) d1 = c; else d2 = c;
            end
        end
        start_a = 1'b0;
        board_a = '0;
        checks++;
        if (dones != 2 || d1 != 21 || d2 != 44) begin failures++; $display("FAIL b2b_timing: dones %0d at %0d,%0d want 2 at 21,44", dones, d1, d2); end
        checks++;
        if (out_a !== E1 || lines_a !== 5'd1 || busy_a !== 1'b0) begin failures++; $display("FAIL b2b_result: board %h lines %0d busy %b", out_a, lines_a, busy_a); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int cyc;
        board_a = B1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_a, done_a, lines_a, score_a} !== '0) begin failures++; $display("FAIL midrst_ctrl: got %h want 0", {busy_a, done_a, lines_a, score_a}); end
        checks++;
        if (out_a !== '0) begin failures++; $display("FAIL midrst_board: got %h want 0", out_a); end
        #3;
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done_a === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || busy_a !== 1'b0) begin failures++; $display("FAIL midrst_nodone: dones %0d busy %b want 0/0", dones, busy_a); end
        run_a(B1, cyc);
        checks++;
        if (cyc != 21 || out_a !== E1 || lines_a !== 5'd1) begin failures++; $display("FAIL midrst_rerun: cyc %0d board %h lines %0d", cyc, out_a, lines_a); end
        finish_a("midrst");
        checks++;
        if (score_a !== (SC ? 16'd1 : 16'd0)) begin failures++; $display("FAIL midrst_score: got %0d want %0d", score_a, SC ? 1 : 0); end
    endtask

    initial begin
        test_reset();
        test_small_board();
        test_single_line();
        test_empty();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
